// File: rtl/scorer_mp.sv
// scorer_mp: multi-player key-press grader with streak multiplier and saturating score accumulators
module scorer_mp #(
  parameter int unsigned N_PLAYERS   = 2,
  parameter int unsigned N_LANES     = 4,
  parameter int unsigned NOTE_W      = 360,
  parameter int unsigned WIN_W       = 14,
  parameter int unsigned INC_W       = 8,
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned STREAK_W    = 8,
  parameter int unsigned STREAK_STEP = 8,
  parameter int unsigned MULT_MAX    = 4
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic                            clear,
  input  logic [N_PLAYERS-1:0]            enable,
  input  logic [N_PLAYERS*N_LANES-1:0]    keyTrack,
  input  logic [N_LANES*NOTE_W-1:0]       n_reg,
  output logic [N_PLAYERS*INC_W-1:0]      inc,
  output logic [N_PLAYERS-1:0]            ld,
  output logic [N_PLAYERS-1:0]            miss,
  output logic [N_PLAYERS*SCORE_W-1:0]    score,
  output logic [N_PLAYERS*STREAK_W-1:0]   streak,
  output logic [N_PLAYERS*3-1:0]          mult
);

  localparam int unsigned KEY_W  = N_PLAYERS * N_LANES;
  localparam int unsigned K_W    = $clog2(WIN_W + 1);
  localparam int unsigned BASE_W = $clog2(N_LANES * WIN_W + 1);
  localparam int unsigned HIT_W  = $clog2(N_LANES + 1);
  localparam int unsigned PROD_W = BASE_W + 3;
  localparam int unsigned SUM_W  = SCORE_W + 1;
  localparam int unsigned STK_W  = STREAK_W + 1;

  // Only the hit window at the top of each note register is graded
  logic w_unused_notes;
  assign w_unused_notes = ^n_reg;

  logic [WIN_W-1:0] w_win [N_LANES];
  logic [K_W-1:0]   w_k   [N_LANES];

  for (genvar l = 0; l < N_LANES; l++) begin : g_win
    assign w_win[l] = n_reg[l*NOTE_W + NOTE_W - 1 -: WIN_W];
  end

  // Lane value: one-hot window bit i grades as i+1, anything else grades as 0
  always_comb begin
    for (int l = 0; l < N_LANES; l++) begin
      w_k[l] = '0;
      if ((w_win[l] != '0) && ((w_win[l] & (w_win[l] - WIN_W'(1))) == '0)) begin
        for (int i = 0; i < WIN_W; i++) begin
          if (w_win[l][i]) w_k[l] = K_W'(i + 1);
        end
      end
    end
  end

  logic [KEY_W-1:0] r_delayed;
  logic [KEY_W-1:0] r_rose;
  logic [KEY_W-1:0] w_en_exp;
  logic             r_armed;

  // Per-player enable fanned out to that player's lanes
  always_comb begin
    w_en_exp = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      for (int l = 0; l < N_LANES; l++) begin
        w_en_exp[p*N_LANES + l] = enable[p];
      end
    end
  end

  // Edge detect; the first edge after reset only primes delayed so keys held through reset stay silent
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_delayed <= '0;
      r_rose    <= '0;
      r_armed   <= 1'b0;
    end else begin
      r_delayed <= keyTrack;
      r_armed   <= 1'b1;
      if (clear || !r_armed) r_rose <= '0;
      else                   r_rose <= keyTrack & ~r_delayed & w_en_exp;
    end
  end

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    logic [INC_W-1:0]    r_inc;
    logic                r_ld;
    logic                r_miss;
    logic [SCORE_W-1:0]  r_score;
    logic [STREAK_W-1:0] r_streak;
    logic [2:0]          r_mult;

    logic [N_LANES-1:0]  w_rose;
    logic [BASE_W-1:0]   w_base;
    logic [HIT_W-1:0]    w_hits;
    logic                w_anymiss;
    logic [PROD_W-1:0]   w_prod;
    logic [INC_W-1:0]    w_inc;
    logic [SUM_W-1:0]    w_sum;
    logic [SCORE_W-1:0]  w_score;
    logic [STK_W-1:0]    w_ssum;
    logic [STREAK_W-1:0] w_streak;
    int unsigned         w_mult_full;
    logic [2:0]          w_mult;

    assign w_rose = r_rose[p*N_LANES +: N_LANES];

    // Grade this player's presses; hits score at the pre-update multiplier even alongside a miss
    always_comb begin
      w_base    = '0;
      w_hits    = '0;
      w_anymiss = 1'b0;
      for (int l = 0; l < N_LANES; l++) begin
        if (w_rose[l]) begin
          if (w_k[l] != '0) begin
            w_base = w_base + BASE_W'(w_k[l]);
            w_hits = w_hits + HIT_W'(1);
          end else begin
            w_anymiss = 1'b1;
          end
        end
      end
      w_prod = PROD_W'(w_base) * PROD_W'(r_mult);
      if ((w_prod >> INC_W) != '0) w_inc = '1;
      else                         w_inc = INC_W'(w_prod);
      w_sum   = {1'b0, r_score} + SUM_W'(w_inc);
      w_score = w_sum[SUM_W-1] ? '1 : w_sum[SCORE_W-1:0];
      w_ssum  = {1'b0, r_streak} + STK_W'(w_hits);
      if (w_anymiss)              w_streak = '0;
      else if (w_ssum[STK_W-1])   w_streak = '1;
      else                        w_streak = w_ssum[STREAK_W-1:0];
      w_mult_full = 1 + (32'(w_streak) / STREAK_STEP);
      w_mult = (w_mult_full > MULT_MAX) ? 3'(MULT_MAX) : 3'(w_mult_full);
    end

    // Event outputs and accumulators; mult is kept in step with the registered streak
    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        r_inc    <= '0;
        r_ld     <= 1'b0;
        r_miss   <= 1'b0;
        r_score  <= '0;
        r_streak <= '0;
        r_mult   <= 3'd1;
      end else if (clear) begin
        r_inc    <= '0;
        r_ld     <= 1'b0;
        r_miss   <= 1'b0;
        r_score  <= '0;
        r_streak <= '0;
        r_mult   <= 3'd1;
      end else begin
        r_inc    <= w_inc;
        r_ld     <= |w_rose;
        r_miss   <= w_anymiss;
        r_score  <= w_score;
        r_streak <= w_streak;
        r_mult   <= w_mult;
      end
    end

    assign inc[p*INC_W +: INC_W]          = r_inc;
    assign ld[p]                          = r_ld;
    assign miss[p]                        = r_miss;
    assign score[p*SCORE_W +: SCORE_W]    = r_score;
    assign streak[p*STREAK_W +: STREAK_W] = r_streak;
    assign mult[p*3 +: 3]                 = r_mult;
  end

endmodule

// File: tb/tb_scorer_mp.sv
// tb_scorer_mp: scoreboard bench for scorer_mp with hand-computed expected events
module tb_scorer_mp;

  localparam int unsigned NP = 2;
  localparam int unsigned NL = 4;
  localparam int unsigned NW = 360;
  localparam int unsigned WW = 14;
  localparam int unsigned IW = 8;
  localparam int unsigned SW = 8;
  localparam int unsigned TW = 8;

  logic              Clk;
  logic              Reset_n;
  logic              clear;
  logic [NP-1:0]     enable;
  logic [NP*NL-1:0]  keyTrack;
  logic [NL*NW-1:0]  n_reg;
  logic [NP*IW-1:0]  inc;
  logic [NP-1:0]     ld;
  logic [NP-1:0]     miss;
  logic [NP*SW-1:0]  score;
  logic [NP*TW-1:0]  streak;
  logic [NP*3-1:0]   mult;

  scorer_mp #(
    .N_PLAYERS(NP), .N_LANES(NL), .NOTE_W(NW), .WIN_W(WW), .INC_W(IW),
    .SCORE_W(SW), .STREAK_W(TW), .STREAK_STEP(8), .MULT_MAX(4)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .clear(clear), .enable(enable),
    .keyTrack(keyTrack), .n_reg(n_reg), .inc(inc), .ld(ld), .miss(miss),
    .score(score), .streak(streak), .mult(mult)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [0:0] p;
    logic [7:0] inc;
    logic       miss;
    logic [7:0] score;
    logic [7:0] streak;
    logic [2:0] mult;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every graded event pops the next expected entry
  always @(negedge Clk) begin
    if (Reset_n) begin
      for (int p = 0; p < NP; p++) begin
        if (ld[p]) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ld: player %0d got ld=1 required no event at %0t", p, $time);
          end else begin
            mon_e = exp_q.pop_front();
            check("ev_player", 32'(p), 32'(mon_e.p));
            check("ev_inc",    32'(inc[p*IW +: IW]),    32'(mon_e.inc));
            check("ev_miss",   32'(miss[p]),            32'(mon_e.miss));
            check("ev_score",  32'(score[p*SW +: SW]),  32'(mon_e.score));
            check("ev_streak", 32'(streak[p*TW +: TW]), 32'(mon_e.streak));
            check("ev_mult",   32'(mult[p*3 +: 3]),     32'(mon_e.mult));
          end
        end else begin
          check("idle_inc_miss", 32'({inc[p*IW +: IW], miss[p]}), 32'(0));
        end
      end
    end
  end

  task automatic set_win(input int l, input logic [WW-1:0] m);
    n_reg[l*NW + NW - WW +: WW] = m;
  endtask

  task automatic push(input int p, input int i, input bit ms, input int sc, input int st, input int mu);
    exp_t e;
    e.p      = 1'(p);
    e.inc    = 8'(i);
    e.miss   = ms;
    e.score  = 8'(sc);
    e.streak = 8'(st);
    e.mult   = 3'(mu);
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [NP*NL-1:0] keys);
    keyTrack = keys;
    @(negedge Clk);
    check("latency_no_ld_yet", 32'(ld), 32'(0));
    @(negedge Clk);
    @(negedge Clk);
    keyTrack = '0;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  task automatic check_zeroed(input string name);
    check({name, "_ld"},     32'(ld),     32'(0));
    check({name, "_inc"},    32'(inc),    32'(0));
    check({name, "_miss"},   32'(miss),   32'(0));
    check({name, "_score"},  32'(score),  32'(0));
    check({name, "_streak"}, 32'(streak), 32'(0));
    check({name, "_mult"},   32'(mult),   32'({3'd1, 3'd1}));
  endtask

  int i_inc [8] = '{4, 4, 8, 8, 12, 12, 16, 16};
  int i_st  [8] = '{4, 8, 12, 16, 20, 24, 28, 32};
  int i_sc  [8] = '{63, 67, 75, 83, 95, 107, 123, 139};
  int i_mu  [8] = '{1, 2, 2, 3, 3, 4, 4, 4};

  initial begin
    Reset_n  = 1'b0;
    clear    = 1'b0;
    enable   = 2'b11;
    keyTrack = '0;
    n_reg    = '1;
    for (int l = 0; l < NL; l++) set_win(l, '0);
    @(negedge Clk);
    @(negedge Clk);
    check_zeroed("reset");
    Reset_n = 1'b1;
    @(negedge Clk);
    @(negedge Clk);

    // single hit k=5
    set_win(0, 14'h0010);
    push(0, 5, 1'b0, 5, 1, 1);
    press(8'b0000_0001);
    check("p1_score_idle",  32'(score[SW +: SW]),  32'(0));
    check("p1_streak_idle", 32'(streak[TW +: TW]), 32'(0));

    // chord k=3 + k=14
    set_win(1, 14'h0004);
    set_win(3, 14'h2000);
    push(0, 17, 1'b0, 22, 3, 1);
    press(8'b0000_1010);

    // five k=1 hits bring streak to 8
    set_win(0, 14'h0001);
    for (int k = 0; k < 5; k++) begin
      push(0, 1, 1'b0, 23 + k, 4 + k, (k == 4) ? 2 : 1);
      press(8'b0000_0001);
    end

    // k=5 at mult 2
    set_win(0, 14'h0010);
    push(0, 10, 1'b0, 37, 9, 2);
    press(8'b0000_0001);

    // miss on empty window, then on two-hot window
    set_win(2, 14'h0000);
    push(0, 0, 1'b1, 37, 0, 1);
    press(8'b0000_0100);
    set_win(2, 14'h0028);
    push(0, 0, 1'b1, 37, 0, 1);
    press(8'b0000_0100);

    // two 4-lane chords of k=1 rebuild streak 8
    for (int l = 0; l < NL; l++) set_win(l, 14'h0001);
    push(0, 4, 1'b0, 41, 4, 1);
    press(8'b0000_1111);
    push(0, 4, 1'b0, 45, 8, 2);
    press(8'b0000_1111);

    // hit k=7 at mult 2 together with a miss
    set_win(0, 14'h0040);
    set_win(2, 14'h0000);
    push(0, 14, 1'b1, 59, 0, 1);
    press(8'b0000_0101);

    // chords climb to the multiplier ceiling
    for (int l = 0; l < NL; l++) set_win(l, 14'h0001);
    for (int k = 0; k < 8; k++) begin
      push(0, i_inc[k], 1'b0, i_sc[k], i_st[k], i_mu[k]);
      press(8'b0000_1111);
    end

    // max chord saturates the 8-bit score
    for (int l = 0; l < NL; l++) set_win(l, 14'h2000);
    push(0, 224, 1'b0, 255, 36, 4);
    press(8'b0000_1111);
    set_win(0, 14'h0010);
    push(0, 20, 1'b0, 255, 37, 4);
    press(8'b0000_0001);

    // disabled player is ignored
    enable = 2'b01;
    press(8'b0001_0000);
    check("disabled_score",  32'(score[SW +: SW]),  32'(0));
    check("disabled_streak", 32'(streak[TW +: TW]), 32'(0));
    enable = 2'b11;

    // both players graded in the same cycle
    set_win(1, 14'h0002);
    push(0, 20, 1'b0, 255, 38, 4);
    push(1, 2, 1'b0, 2, 1, 1);
    press(8'b0010_0001);

    // clear overrides a pending event; held key does not retrigger
    keyTrack = 8'b0000_0001;
    @(negedge Clk);
    clear = 1'b1;
    @(negedge Clk);
    clear = 1'b0;
    check_zeroed("clear");
    @(negedge Clk);
    @(negedge Clk);
    keyTrack = '0;
    @(negedge Clk);
    @(negedge Clk);

    push(0, 5, 1'b0, 5, 1, 1);
    press(8'b0000_0001);

    // reset mid-stream with a key held and an event pending
    keyTrack = 8'b0000_0001;
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check_zeroed("midreset");
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    keyTrack = '0;
    repeat (2) @(negedge Clk);

    push(0, 5, 1'b0, 5, 1, 1);
    press(8'b0000_0001);

    repeat (4) @(negedge Clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
